soc_mem_fabric: RTL and testbench
=================================

Name: soc_mem_fabric

Overview:
- Parametrised native-memory-bus interconnect between the picorv32 core and NUM_SLV slaves (SRAM, peripherals).
- Decodes the address upper bits to select a slave and broadcasts the request to it.
- Aborts hung or unmapped accesses with a watchdog timeout, a fixed error read value and an interrupt pulse.
- Sits at SoC top between CORE and the SRAM/peripheral instances.

Parameters:
- NUM_SLV, 4, number of slave ports (1..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- SEL_LSB, 24, lowest address bit of the slave-select field; index = mem_addr[ADDR_W-1:SEL_LSB].
- TIMEOUT_CYC, 64, max cycles a slave may take to assert ready (>=2).

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- mem_valid  in  1  master request valid, held until mem_ready
- mem_instr  in  1  instruction-fetch qualifier
- mem_addr  in  ADDR_W  request address
- mem_wdata  in  DATA_W  write data
- mem_wstrb  in  DATA_W/8  byte strobes; 0 means read
- mem_rdata  out  DATA_W  read data, valid while mem_ready=1
- mem_ready  out  1  one-cycle completion pulse
- s_valid  out  NUM_SLV  per-slave request, one-hot or zero
- s_instr  out  1  broadcast
- s_addr  out  ADDR_W  broadcast, full address
- s_wdata  out  DATA_W  broadcast
- s_wstrb  out  DATA_W/8  broadcast
- s_rdata  in  NUM_SLV*DATA_W  concatenated slave read data; slave i at [i*DATA_W +: DATA_W]
- s_ready  in  NUM_SLV  per-slave completion
- bus_err_irq  out  1  one-cycle pulse on any error completion

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE, timeout counter=0, sel=0; s_valid=0, mem_ready=0, mem_rdata=0, bus_err_irq=0. A reset mid-transaction abandons it silently, with no ready and no irq.
- States: IDLE, ACT, ERR, DONE.
- IDLE:
  - On mem_valid, register the index and the request fields (addr/wdata/wstrb/instr).
  - If index < NUM_SLV, go to ACT; otherwise go to ERR.
  - mem_ready=0 in this state.
- ACT:
  - s_valid[sel]=1 from the first ACT cycle; registered, so request latency is 1 cycle after mem_valid.
  - s_addr/s_wdata/s_wstrb/s_instr are driven from the registered copy and are stable throughout.
  - If s_ready[sel]=1: mem_ready=1 and mem_rdata=s_rdata[sel] combinationally in that cycle; go to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYC-1 without s_ready, go to ERR.
  - s_ready on the same cycle as the terminal count counts as success.
  - s_ready from non-selected slaves is ignored.
- ERR (1 cycle):
  - s_valid=0, mem_ready=1, mem_rdata=ERR_DATA (32'hDEAD_BEEF, truncated or zero-extended to DATA_W), bus_err_irq=1.
  - Writes are discarded. Go to DONE.
- DONE (1 cycle):
  - All outputs are inactive, mem_valid is ignored, the counter clears. Go to IDLE.
  - This guarantees the master's deasserting edge is never mistaken for a new request.
- Timing: minimum access is 3 cycles from mem_valid to IDLE re-entry (IDLE, ACT with same-cycle ready, DONE).
- Counter width is clog2(TIMEOUT_CYC). It never wraps because it is cleared in IDLE and DONE.
- mem_rdata is 0 whenever mem_ready=0.

Optional Feature:
- Macro SOC_FABRIC_ERRCAP_EN.
- When defined:
  - Extra outputs err_addr[ADDR_W] (address of the most recent error) and err_cnt[8] (count of error completions, saturating at 255).
  - err_valid[1] is set on the first error and sticky until reset.
  - All three reset to 0 and update on the ERR cycle.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package soc_fabric_pkg holds:
  - state enum fabric_state_e {IDLE, ACT, ERR, DONE};
  - localparam ERR_DATA = 32'hDEAD_BEEF;
  - function sel_valid(idx, NUM_SLV).
- One sub-module, soc_fabric_wdt:
  - inputs clk, rstn, run, clear;
  - output expired;
  - parameter TIMEOUT_CYC.

Test Plan:
- Read from slave 1 at 0x0100_0010; slave returns s_ready after 2 cycles with 0x1234_5678 -> s_valid=4'b0010 one cycle after mem_valid, mem_ready pulses once with mem_rdata=0x1234_5678, bus_err_irq stays 0.
- Write 0x0300_0004, wstrb=4'b0011, wdata=0xAABB_CCDD; slave 3 readies the same cycle -> s_wstrb/s_wdata match, s_valid=4'b1000 for exactly 1 cycle, mem_ready 1 cycle.
- Unmapped access 0x0700_0000 -> no s_valid ever, mem_ready at cycle 2 with mem_rdata=0xDEAD_BEEF, bus_err_irq pulse 1 cycle.
- Slave 0 never readies (TIMEOUT_CYC=64) -> s_valid high for 64 cycles, then ERR completion with 0xDEAD_BEEF and irq; a late s_ready afterwards is ignored.
- s_ready asserted exactly on the terminal-count cycle -> success completion, no irq. Separately, assert rstn=0 mid-ACT -> all outputs 0 immediately, next request works normally.
- With SOC_FABRIC_ERRCAP_EN: 300 unmapped accesses -> err_cnt=255, err_addr = last address, err_valid=1.

Source files
------------

// File: rtl/soc_fabric_pkg.sv
// Shared types and constants for the native memory bus fabric.
// Used by soc_mem_fabric and soc_fabric_wdt.
package soc_fabric_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACT,
    ERR,
    DONE
  } fabric_state_e;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  function automatic logic sel_valid(
    input int unsigned idx,
    input int unsigned num_slv
  );
    return idx < num_slv;
  endfunction

endpackage

// File: rtl/soc_fabric_wdt.sv
// Access watchdog: counts stalled ACT cycles, flags the terminal count.
// Holds at the terminal count so it never wraps.
module soc_fabric_wdt #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rstn,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  assign expired = (cnt == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/soc_mem_fabric.sv
// picorv32 native bus to NUM_SLV slave fabric with timeout abort.
// Define SOC_FABRIC_ERRCAP_EN for err_addr/err_cnt/err_valid capture.
module soc_mem_fabric
  import soc_fabric_pkg::*;
#(
  parameter int NUM_SLV     = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SEL_LSB     = 24,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      mem_valid,
  input  logic                      mem_instr,
  input  logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W/8-1:0]       mem_wstrb,
  output logic [DATA_W-1:0]         mem_rdata,
  output logic                      mem_ready,
  output logic [NUM_SLV-1:0]        s_valid,
  output logic                      s_instr,
  output logic [ADDR_W-1:0]         s_addr,
  output logic [DATA_W-1:0]         s_wdata,
  output logic [DATA_W/8-1:0]       s_wstrb,
  input  logic [NUM_SLV*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLV-1:0]        s_ready,
  output logic                      bus_err_irq
`ifdef SOC_FABRIC_ERRCAP_EN
  ,
  output logic [ADDR_W-1:0]         err_addr,
  output logic [7:0]                err_cnt,
  output logic                      err_valid
`endif
);

  localparam int IDX_W = ADDR_W - SEL_LSB;
  localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [DATA_W-1:0] ERR_D = DATA_W'(ERR_DATA);

  fabric_state_e state_q, state_d;

  logic [SEL_W-1:0]    sel_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                instr_q;

  logic [IDX_W-1:0]  idx;
  logic              hit;
  logic              run;
  logic              clear;
  logic              expired;
  logic [DATA_W-1:0] rd [NUM_SLV];

  assign idx = mem_addr[ADDR_W-1:SEL_LSB];
  assign hit = sel_valid(32'(idx), NUM_SLV);

  for (genvar i = 0; i < NUM_SLV; i++) begin : g_rd
    assign rd[i] = s_rdata[i*DATA_W +: DATA_W];
  end

  soc_fabric_wdt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdt (
    .clk    (clk),
    .rstn   (rstn),
    .run    (run),
    .clear  (clear),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      instr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && mem_valid) begin
        sel_q   <= SEL_W'(idx);
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
        instr_q <= mem_instr;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_ready   = 1'b0;
    mem_rdata   = '0;
    bus_err_irq = 1'b0;
    s_valid     = '0;
    run         = 1'b0;
    clear       = 1'b0;
    unique case (state_q)
      IDLE: begin
        clear = 1'b1;
        if (mem_valid) state_d = hit ? ACT : ERR;
      end
      ACT: begin
        s_valid[sel_q] = 1'b1;
        if (s_ready[sel_q]) begin
          mem_ready = 1'b1;
          mem_rdata = rd[sel_q];
          state_d   = DONE;
        end else if (expired) begin
          state_d = ERR;
        end else begin
          run = 1'b1;
        end
      end
      ERR: begin
        mem_ready   = 1'b1;
        mem_rdata   = ERR_D;
        bus_err_irq = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        clear   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_instr = instr_q;
  assign s_addr  = addr_q;
  assign s_wdata = wdata_q;
  assign s_wstrb = wstrb_q;

`ifdef SOC_FABRIC_ERRCAP_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_addr  <= '0;
      err_cnt   <= '0;
      err_valid <= 1'b0;
    end else if (state_q == ERR) begin
      err_addr  <= addr_q;
      err_valid <= 1'b1;
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_soc_mem_fabric.sv
// Directed self-checking bench for soc_mem_fabric (default parameters).
// Define SOC_FABRIC_ERRCAP_EN to also exercise the error capture block.
module tb_soc_mem_fabric;

  logic         clk = 1'b0;
  logic         rstn;
  logic         mem_valid;
  logic         mem_instr;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_wstrb;
  logic [31:0]  mem_rdata;
  logic         mem_ready;
  logic [3:0]   s_valid;
  logic         s_instr;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic [3:0]   s_wstrb;
  logic [127:0] s_rdata;
  logic [3:0]   s_ready;
  logic         bus_err_irq;
`ifdef SOC_FABRIC_ERRCAP_EN
  logic [31:0]  err_addr;
  logic [7:0]   err_cnt;
  logic         err_valid;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  soc_mem_fabric dut (
    .clk        (clk),
    .rstn       (rstn),
    .mem_valid  (mem_valid),
    .mem_instr  (mem_instr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .s_valid    (s_valid),
    .s_instr    (s_instr),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_rdata    (s_rdata),
    .s_ready    (s_ready),
    .bus_err_irq(bus_err_irq)
`ifdef SOC_FABRIC_ERRCAP_EN
    ,
    .err_addr   (err_addr),
    .err_cnt    (err_cnt),
    .err_valid  (err_valid)
`endif
  );

  task automatic step;
    @(negedge clk);
  endtask

  task automatic idle_bus;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    s_ready   = '0;
    s_rdata   = '0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    idle_bus();
    step();
    #1;
    vecs++;
    if (s_valid !== 4'b0 || mem_ready !== 1'b0) begin
      errs++;
      $display("FAIL rst_ctl got v=%b r=%b want 0 0", s_valid, mem_ready);
    end
    vecs++;
    if (mem_rdata !== 32'h0 || bus_err_irq !== 1'b0) begin
      errs++;
      $display("FAIL rst_data got d=%h irq=%b want 0 0", mem_rdata, bus_err_irq);
    end
    vecs++;
    if (s_addr !== 32'h0) begin
      errs++;
      $display("FAIL rst_addr got %h want 0", s_addr);
    end
    step();
    rstn = 1'b1;
  endtask

  task automatic test_read;
    int rdy_seen;
    step();
    mem_valid = 1'b1;
    mem_instr = 1'b1;
    mem_addr  = 32'h0100_0010;
    s_rdata   = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'h0000_0000};
    #1;
    vecs++;
    if (s_valid !== 4'b0000 || mem_ready !== 1'b0) begin
      errs++;
      $display("FAIL rd_idle got v=%b r=%b want 0000 0", s_valid, mem_ready);
    end
    step();
    s_ready = 4'b1101;
    #1;
    vecs++;
    if (s_valid !== 4'b0010 || mem_ready !== 1'b0) begin
      errs++;
      $display("FAIL rd_act1 got v=%b r=%b want 0010 0", s_valid, mem_ready);
    end
    vecs++;
    if (s_addr !== 32'h0100_0010 || s_instr !== 1'b1 || s_wstrb !== 4'b0) begin
      errs++;
      $display("FAIL rd_bcast got a=%h i=%b s=%b want 01000010 1 0000", s_addr, s_instr, s_wstrb);
    end
    step();
    s_ready = 4'b0000;
    #1;
    vecs++;
    if (mem_ready !== 1'b0 || mem_rdata !== 32'h0) begin
      errs++;
      $display("FAIL rd_act2 got r=%b d=%h want 0 0", mem_ready, mem_rdata);
    end
    step();
    s_ready = 4'b0010;
    #1;
    vecs++;
    if (mem_ready !== 1'b1 || mem_rdata !== 32'h1234_5678 || bus_err_irq !== 1'b0) begin
      errs++;
      $display("FAIL rd_done got r=%b d=%h irq=%b want 1 12345678 0", mem_ready, mem_rdata, bus_err_irq);
    end
    rdy_seen = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      mem_valid = 1'b0;
      s_ready   = 4'b0000;
      #1;
      if (mem_ready === 1'b1 || bus_err_irq === 1'b1) rdy_seen++;
    end
    vecs++;
    if (rdy_seen !== 0) begin
      errs++;
      $display("FAIL rd_after got %0d extra pulses want 0", rdy_seen);
    end
    idle_bus();
  endtask

  task automatic test_write;
    step();
    mem_valid = 1'b1;
    mem_addr  = 32'h0300_0004;
    mem_wdata = 32'hAABB_CCDD;
    mem_wstrb = 4'b0011;
    step();
    s_ready = 4'b1000;
    #1;
    vecs++;
    if (s_valid !== 4'b1000 || mem_ready !== 1'b1) begin
      errs++;
      $display("FAIL wr_act got v=%b r=%b want 1000 1", s_valid, mem_ready);
    end
    vecs++;
    if (s_wdata !== 32'hAABB_CCDD || s_wstrb !== 4'b0011) begin
      errs++;
      $display("FAIL wr_bcast got d=%h s=%b want aabbccdd 0011", s_wdata, s_wstrb);
    end
    step();
    s_ready = 4'b0000;
    #1;
    vecs++;
    if (s_valid !== 4'b0000 || mem_ready !== 1'b0) begin
      errs++;
      $display("FAIL wr_done_ign got v=%b r=%b want 0000 0", s_valid, mem_ready);
    end
    step();
    mem_valid = 1'b0;
    step();
    #1;
    vecs++;
    if (s_valid !== 4'b0000 || mem_ready !== 1'b0) begin
      errs++;
      $display("FAIL wr_no_retrig got v=%b r=%b want 0000 0", s_valid, mem_ready);
    end
    idle_bus();
  endtask

  task automatic test_unmapped;
    step();
    mem_valid = 1'b1;
    mem_addr  = 32'h0700_0000;
    #1;
    vecs++;
    if (s_valid !== 4'b0 || mem_ready !== 1'b0) begin
      errs++;
      $display("FAIL um_idle got v=%b r=%b want 0000 0", s_valid, mem_ready);
    end
    step();
    #1;
    vecs++;
    if (s_valid !== 4'b0 || mem_ready !== 1'b1 || bus_err_irq !== 1'b1) begin
      errs++;
      $display("FAIL um_err got v=%b r=%b irq=%b want 0000 1 1", s_valid, mem_ready, bus_err_irq);
    end
    vecs++;
    if (mem_rdata !== 32'hDEAD_BEEF) begin
      errs++;
      $display("FAIL um_data got %h want deadbeef", mem_rdata);
    end
    step();
    mem_valid = 1'b0;
    #1;
    vecs++;
    if (mem_ready !== 1'b0 || bus_err_irq !== 1'b0 || mem_rdata !== 32'h0) begin
      errs++;
      $display("FAIL um_done got r=%b irq=%b d=%h want 0 0 0", mem_ready, bus_err_irq, mem_rdata);
    end
    idle_bus();
  endtask

  task automatic test_timeout;
    int hi;
    step();
    mem_valid = 1'b1;
    mem_addr  = 32'h0000_0100;
    s_rdata   = {96'h0, 32'h5555_5555};
    hi = 0;
    for (int k = 0; k < 64; k++) begin
      step();
      #1;
      if (s_valid === 4'b0001 && mem_ready === 1'b0) hi++;
    end
    vecs++;
    if (hi !== 64) begin
      errs++;
      $display("FAIL to_span got %0d cycles want 64", hi);
    end
    step();
    #1;
    vecs++;
    if (mem_ready !== 1'b1 || mem_rdata !== 32'hDEAD_BEEF || bus_err_irq !== 1'b1 || s_valid !== 4'b0) begin
      errs++;
      $display("FAIL to_err got r=%b d=%h irq=%b v=%b want 1 deadbeef 1 0000",
               mem_ready, mem_rdata, bus_err_irq, s_valid);
    end
    step();
    s_ready = 4'b0001;
    #1;
    vecs++;
    if (mem_ready !== 1'b0 || mem_rdata !== 32'h0) begin
      errs++;
      $display("FAIL to_late got r=%b d=%h want 0 0", mem_ready, mem_rdata);
    end
    step();
    mem_valid = 1'b0;
    #1;
    vecs++;
    if (mem_ready !== 1'b0 || s_valid !== 4'b0) begin
      errs++;
      $display("FAIL to_late2 got r=%b v=%b want 0 0000", mem_ready, s_valid);
    end
    idle_bus();
  endtask

  task automatic test_terminal;
    step();
    mem_valid = 1'b1;
    mem_addr  = 32'h0200_0000;
    s_rdata   = {32'h0, 32'hCAFE_F00D, 64'h0};
    for (int k = 0; k < 63; k++) begin
      step();
    end
    step();
    s_ready = 4'b0100;
    #1;
    vecs++;
    if (mem_ready !== 1'b1 || mem_rdata !== 32'hCAFE_F00D || bus_err_irq !== 1'b0) begin
      errs++;
      $display("FAIL tc_ok got r=%b d=%h irq=%b want 1 cafef00d 0", mem_ready, mem_rdata, bus_err_irq);
    end
    step();
    s_ready   = 4'b0000;
    mem_valid = 1'b0;
    #1;
    vecs++;
    if (mem_ready !== 1'b0 || bus_err_irq !== 1'b0) begin
      errs++;
      $display("FAIL tc_done got r=%b irq=%b want 0 0", mem_ready, bus_err_irq);
    end
    idle_bus();
  endtask

  task automatic test_reset_mid;
    int bad;
    step();
    mem_valid = 1'b1;
    mem_addr  = 32'h0100_0000;
    s_rdata   = {64'h0, 32'h7777_8888, 32'h0};
    step();
    step();
    s_ready = 4'b0010;
    #1;
    vecs++;
    if (mem_ready !== 1'b1) begin
      errs++;
      $display("FAIL rm_pre got r=%b want 1", mem_ready);
    end
    #1;
    rstn = 1'b0;
    #1;
    vecs++;
    if (s_valid !== 4'b0 || mem_ready !== 1'b0 || mem_rdata !== 32'h0 || bus_err_irq !== 1'b0) begin
      errs++;
      $display("FAIL rm_async got v=%b r=%b d=%h irq=%b want 0 0 0 0",
               s_valid, mem_ready, mem_rdata, bus_err_irq);
    end
    idle_bus();
    step();
    rstn = 1'b1;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      #1;
      if (mem_ready === 1'b1 || bus_err_irq === 1'b1 || s_valid !== 4'b0) bad++;
    end
    vecs++;
    if (bad !== 0) begin
      errs++;
      $display("FAIL rm_quiet got %0d active cycles want 0", bad);
    end
    step();
    mem_valid = 1'b1;
    mem_addr  = 32'h0200_0040;
    s_rdata   = {32'h0, 32'h0BAD_F00D, 64'h0};
    step();
    s_ready = 4'b0100;
    #1;
    vecs++;
    if (s_valid !== 4'b0100 || mem_ready !== 1'b1 || mem_rdata !== 32'h0BAD_F00D) begin
      errs++;
      $display("FAIL rm_next got v=%b r=%b d=%h want 0100 1 0badf00d", s_valid, mem_ready, mem_rdata);
    end
    step();
    mem_valid = 1'b0;
    s_ready   = 4'b0000;
    step();
    idle_bus();
  endtask

`ifdef SOC_FABRIC_ERRCAP_EN
  task automatic test_errcap;
    step();
    #1;
    vecs++;
    if (err_cnt !== 8'd0 || err_valid !== 1'b0) begin
      errs++;
      $display("FAIL ec_init got c=%0d v=%b want 0 0", err_cnt, err_valid);
    end
    for (int i = 0; i < 300; i++) begin
      step();
      mem_valid = 1'b1;
      mem_addr  = (i == 299) ? 32'hF000_0ABC : 32'h0400_0000 + 32'(i * 4);
      step();
      step();
      mem_valid = 1'b0;
      if (i == 0) begin
        #1;
        vecs++;
        if (err_cnt !== 8'd1 || err_valid !== 1'b1 || err_addr !== 32'h0400_0000) begin
          errs++;
          $display("FAIL ec_first got c=%0d v=%b a=%h want 1 1 04000000", err_cnt, err_valid, err_addr);
        end
      end
    end
    step();
    #1;
    vecs++;
    if (err_cnt !== 8'd255 || err_valid !== 1'b1 || err_addr !== 32'hF000_0ABC) begin
      errs++;
      $display("FAIL ec_sat got c=%0d v=%b a=%h want 255 1 f0000abc", err_cnt, err_valid, err_addr);
    end
    idle_bus();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog sim time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_unmapped();
    test_timeout();
    test_terminal();
    test_reset_mid();
`ifdef SOC_FABRIC_ERRCAP_EN
    test_errcap();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
